fp_normalize_left: RTL and testbench
====================================

// Module: fp_normalize_left
// PURPOSE
//  Post-add normaliser/packer for the single-precision FP adder; inverse of the right-shift alignment stage.
//  Takes the signed sum magnitude and common exponent and normalises it:
//   - carry-out: right-shifts one bit;
//   - cancellation: left-shifts one bit per clock.
//  Then rounds to nearest-even and packs an IEEE-754 single.
//  Iterative FSM with valid/ready handshakes on both sides; one operation in flight at a time.
// PARAMETERS
//  ROUND_EN   1   1 = round-to-nearest-even on guard/sticky; 0 = truncate (skip rounding increment)
//  MAX_SHIFT  25  left-shift cycles allowed before forcing result to zero (>= 25 required)
// PORTS
//  clk        in   1   clock, all state on rising edge
//  res        in   1   reset, asynchronous, active-low
//  in_valid   in   1   operand valid
//  in_ready   out  1   block can accept operand (high only in IDLE)
//  in_sign    in   1   sign of sum
//  in_exp     in   8   biased exponent of aligned operands (1..254)
//  in_mag     in   27  [26] carry-out, [25] hidden 1, [24:2] fraction, [1] guard, [0] sticky
//  out_valid  out  1   result valid
//  out_ready  in   1   consumer accepts result
//  result     out  32  packed IEEE-754 single {sign, exp[7:0], frac[22:0]}
//  shift_cnt  out  5   left-shift cycles used by last operation (debug/perf)
// BEHAVIOUR
//  Reset (res=0, async, any state incl. mid-operation): state=IDLE, in_ready=1, out_valid=0,
//   result=0, shift_cnt=0, internal mag/exp/sign=0.
//  Internal regs: s (sign), e (10-bit, for overflow detection), m[26:0], cnt[4:0].
//  IDLE: in_ready=1. Transfer on in_valid&in_ready.
//   - Capture s, e, m; cnt=0; next state CHECK.
//  CHECK (1 cycle):
//   - m==0 -> PACK with result forced +0 (sign 0, exp 0, frac 0).
//   - m[26]=1 -> m = {1'b0, m[26:2], m[1]|m[0]}; e = e+1; next ROUND.
//   - m[25]=1 -> ROUND.
//   - else -> SHIFT.
//  SHIFT (1 cycle per bit):
//   - If m[25]=0 and e>1: m = m<<1 (0 into bit 0), e = e-1, cnt = cnt+1.
//   - Leave for ROUND when m[25]=1, when e==1 (denormal: exp field becomes 0, no further shift),
//     or when cnt==MAX_SHIFT.
//   - Check is on registered m/e, so the exit decision is made the cycle after the last shift.
//  ROUND (1 cycle), ROUND_EN=1: increment fraction m[25:2] when
//   m[1] & (m[0] | m[2]).
//   - Increment carrying into bit 26: renormalise m>>1, e = e+1.
//   - Denormal whose increment sets bit 25: becomes normal with exp 1.
//  PACK (1 cycle):
//   - e>=255 -> result = {s, 8'hFF, 23'h0} (infinity).
//   - Denormal (m[25]=0 after shifting stopped at e==1) -> {s, 8'h00, m[24:2]}.
//   - Else {s, e[7:0], m[24:2]}.
//   - shift_cnt = cnt; out_valid=1; next HOLD.
//  HOLD: result/out_valid stable until out_ready=1; then out_valid=0, state IDLE (in_ready=1 next cycle).
//   - No same-cycle accept on the output-handshake cycle.
//  Latency from input handshake to out_valid:
//   - 4 cycles with no left shift (CHECK, ROUND, PACK, +1 capture);
//   - plus 1 cycle per left shift, plus 1 exit-check cycle when any shift occurs.
//   - Maximum 4+25+1 = 30.
//  in_valid while busy: ignored (in_ready=0); input must be held by producer.
//  in_exp outside 1..254 on input: undefined result; not checked.
// TESTING
//  1.0+1.0: in_mag=27'h4000000, in_exp=127, s=0 -> result=32'h40000000, shift_cnt=0
//  Cancellation: in_mag=27'h0800000 (bit 23), in_exp=130 -> result=32'h40000000, shift_cnt=2,
//   out_valid 7 cycles after accept
//  Tie-to-even carry: in_mag={2'b01, 23'h7FFFFF, 2'b10}, in_exp=127 -> result=32'h40000000
//  Overflow: in_mag=27'h4000000, in_exp=254, s=1 -> result=32'hFF800000
//  Zero/denormal: in_mag=0 -> 32'h00000000; in_mag=27'h0000004, in_exp=1 -> 32'h00000001, shift_cnt=0
//  Backpressure + reset: hold out_ready=0 10 cycles, result stable;
//   assert res=0 mid-SHIFT -> out_valid=0, in_ready=1 immediately (async)

Source files
------------

// File: rtl/fp_normalize_left.sv
// Post-add normaliser/packer for the single-precision FP adder: renormalises the
// aligned sum (one left shift per clock), rounds to nearest-even and packs an IEEE-754 single.
module fp_normalize_left #(
  parameter bit          ROUND_EN  = 1'b1,
  parameter int unsigned MAX_SHIFT = 25
) (
  input  logic        clk,
  input  logic        res,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [26:0] in_mag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [4:0]  shift_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    SHIFT = 3'd2,
    ROUND = 3'd3,
    PACK  = 3'd4,
    HOLD  = 3'd5
  } state_e;

  localparam logic [4:0] MAX_CNT = 5'(MAX_SHIFT);

  state_e      state_q, state_d;
  logic        s_q, s_d;
  logic [9:0]  e_q, e_d;
  logic [26:0] m_q, m_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        zero_q, zero_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  shift_cnt_q, shift_cnt_d;

  logic        rnd_inc;
  logic [24:0] rnd_sum;
  logic [26:0] rnd_full;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign result    = result_q;
  assign shift_cnt = shift_cnt_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    s_d         = s_q;
    e_d         = e_q;
    m_d         = m_q;
    cnt_d       = cnt_q;
    zero_d      = zero_q;
    result_d    = result_q;
    shift_cnt_d = shift_cnt_q;
    rnd_inc     = ROUND_EN && m_q[1] && (m_q[0] || m_q[2]);
    rnd_sum     = {1'b0, m_q[25:2]} + 25'd1;
    rnd_full    = {rnd_sum, m_q[1:0]};

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = in_sign;
          e_d     = {2'b00, in_exp};
          m_d     = in_mag;
          cnt_d   = '0;
          zero_d  = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (m_q == '0) begin
          zero_d  = 1'b1;
          state_d = PACK;
        end else if (m_q[26]) begin
          // Carry-out: fold the dropped guard into sticky.
          m_d     = {1'b0, m_q[26:2], m_q[1] | m_q[0]};
          e_d     = e_q + 10'd1;
          state_d = ROUND;
        end else if (m_q[25]) begin
          state_d = ROUND;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Exit is decided on the registered m/e, one cycle after the last shift.
        if (m_q[25] || (e_q <= 10'd1)) begin
          state_d = ROUND;
        end else if (cnt_q == MAX_CNT) begin
          zero_d  = 1'b1;
          state_d = ROUND;
        end else begin
          m_d   = {m_q[25:0], 1'b0};
          e_d   = e_q - 10'd1;
          cnt_d = cnt_q + 5'd1;
        end
      end
      ROUND: begin
        if (rnd_inc) begin
          if (rnd_sum[24]) begin
            m_d = {1'b0, rnd_full[26:1]};
            e_d = e_q + 10'd1;
          end else begin
            m_d = rnd_full;
          end
        end
        state_d = PACK;
      end
      PACK: begin
        shift_cnt_d = cnt_q;
        if (zero_q)              result_d = '0;
        else if (e_q >= 10'd255) result_d = {s_q, 8'hFF, 23'h0};
        else if (!m_q[25])       result_d = {s_q, 8'h00, m_q[24:2]};
        else                     result_d = {s_q, e_q[7:0], m_q[24:2]};
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q     <= IDLE;
      s_q         <= 1'b0;
      e_q         <= '0;
      m_q         <= '0;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      result_q    <= '0;
      shift_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q     <= state_d;
      s_q         <= s_d;
      e_q         <= e_d;
      m_q         <= m_d;
      cnt_q       <= cnt_d;
      zero_q      <= zero_d;
      result_q    <= result_d;
      shift_cnt_q <= shift_cnt_d;
    end
  end

endmodule

// File: tb/tb_fp_normalize_left.sv
// Self-checking bench for fp_normalize_left: directed corner cases plus randomized
// operands compared against an arithmetic reference model.
module tb_fp_normalize_left;

  logic        clk;
  logic        res;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [26:0] in_mag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  shift_cnt;

  int checks   = 0;
  int failures = 0;

  fp_normalize_left dut (
    .clk       (clk),
    .res       (res),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mag    (in_mag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .shift_cnt (shift_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: locate the leading one, normalise in one step (limited by the
  // exponent floor of 1), then round-to-nearest-even on guard/sticky and pack.
  // lat = clocks from accept to out_valid when well defined, else 0.
  function automatic void model(input logic sg, input int ex, input logic [26:0] mg,
                                output logic [31:0] r, output int sh, output int lat);
    int     p;
    int     e;
    longint m;
    longint kept;
    sh  = 0;
    lat = 0;
    if (mg == 27'd0) begin
      r = 32'h0;
      return;
    end
    p = 26;
    while (!mg[p]) p--;
    m = longint'(mg);
    e = ex;
    if (p == 26) begin
      m   = (m >> 1) | (m & 1);
      e   = ex + 1;
      lat = 4;
    end else if (p == 25) begin
      lat = 4;
    end else begin
      sh = 25 - p;
      if (sh > ex - 1) sh = ex - 1;
      m   = m << sh;
      e   = ex - sh;
      lat = (sh > 0) ? 5 + sh : 0;
    end
    kept = m >> 2;
    if (m[1] && (m[0] || kept[0])) kept = kept + 1;
    if (kept >= (64'd1 << 24)) begin
      kept = kept >> 1;
      e    = e + 1;
    end
    if (e >= 255)                    r = {sg, 8'hFF, 23'h0};
    else if (kept < (64'd1 << 23))   r = {sg, 8'h00, kept[22:0]};
    else                             r = {sg, e[7:0], kept[22:0]};
  endfunction

  // Sends one operand, waits (bounded) for the result, checks it, applies
  // `hold` cycles of backpressure and then completes the output handshake.
  task automatic run_op(input logic sg, input logic [7:0] ex, input logic [26:0] mg,
                        input int hold, input string tag);
    logic [31:0] er;
    int          esh;
    int          elat;
    int          k;
    model(sg, int'(ex), mg, er, esh, elat);
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_sign  = sg;
    in_exp   = ex;
    in_mag   = mg;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_sign  = 1'($urandom);
    in_exp   = 8'($urandom);
    in_mag   = 27'($urandom);
    k = 0;
    while (!out_valid && k < 40) begin
      check({tag, " in_ready busy"}, {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      k++;
    end
    check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, " result"}, result, er);
    check({tag, " shift_cnt"}, {27'd0, shift_cnt}, 32'(esh));
    if (elat != 0) check({tag, " latency"}, 32'(k + 1), 32'(elat));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, " hold result"}, result, er);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " valid drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, " ready back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [26:0] mg;
    logic [7:0]  ex;
    int          kbits;
    int          k;

    res       = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 8'd0;
    in_mag    = 27'd0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset in_ready",  {31'd0, in_ready},  32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset result",    result,             32'h0);
    check("reset shift_cnt", {27'd0, shift_cnt}, 32'd0);
    res = 1'b1;

    // Directed cases with hand-derived results.
    run_op(1'b0, 8'd127, 27'h4000000, 0, "one_plus_one");
    check("one_plus_one const", result, 32'h40000000);
    run_op(1'b0, 8'd130, 27'h0800000, 0, "cancel2");
    check("cancel2 const",     result,             32'h40000000);
    check("cancel2 cnt const", {27'd0, shift_cnt}, 32'd2);
    run_op(1'b0, 8'd127, {2'b01, 23'h7FFFFF, 2'b10}, 0, "tie_even");
    check("tie_even const", result, 32'h40000000);
    run_op(1'b1, 8'd254, 27'h4000000, 0, "overflow");
    check("overflow const", result, 32'hFF800000);
    run_op(1'b1, 8'd90, 27'h0, 0, "zero");
    check("zero const", result, 32'h00000000);
    run_op(1'b0, 8'd1, 27'h0000004, 0, "denormal");
    check("denormal const",     result,             32'h00000001);
    check("denormal cnt const", {27'd0, shift_cnt}, 32'd0);
    run_op(1'b0, 8'd200, 27'h0000001, 0, "max_shift");
    run_op(1'b0, 8'd3, 27'h0100000, 0, "denorm_stop");

    // Backpressure: result and out_valid must hold steady.
    run_op(1'b1, 8'd100, 27'h1234567, 10, "backpressure");

    // Asynchronous reset in the middle of a long shift sequence.
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = 1'b0;
    in_exp   = 8'd200;
    in_mag   = 27'h0000001;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("mid-shift busy", {31'd0, in_ready}, 32'd0);
    res = 1'b0;
    #1;
    check("async in_ready",  {31'd0, in_ready},  32'd1);
    check("async out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("async result",    result,             32'h0);
    check("async shift_cnt", {27'd0, shift_cnt}, 32'd0);
    res = 1'b1;
    run_op(1'b0, 8'd127, 27'h4000000, 0, "after_reset");

    // Randomized operands, leading-one position and exponent region both varied.
    for (int n = 0; n < 150; n++) begin
      kbits = $urandom_range(0, 27);
      mg    = 27'($urandom);
      if (kbits == 0) mg = 27'd0;
      else            mg = (mg & 27'((64'd1 << kbits) - 1)) | 27'(64'd1 << (kbits - 1));
      k = $urandom_range(0, 3);
      if (k == 0)      ex = 8'($urandom_range(1, 4));
      else if (k == 1) ex = 8'($urandom_range(250, 254));
      else             ex = 8'($urandom_range(1, 254));
      run_op(1'($urandom), ex, mg, $urandom_range(0, 2), $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
